posit_accum_ctrl: RTL and testbench

// - Initiator side of the posit adder start/done interface: accepts a stream of posit operands,

---
 rtl/posit_accum_ctrl_pkg.sv | 21 ++
 rtl/posit_accum_ctrl.sv | 166 ++++++++++++++++
 tb/tb_posit_accum_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/posit_accum_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | posit_accum_ctrl_pkg : shared types and defaults for posit_accum_ctrl     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package posit_accum_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_WAIT = 2'd2,
      S_OUT  = 2'd3
   } state_e;

   localparam int DEF_N       = 8;
   localparam int DEF_STAGES  = 1;
   localparam int DEF_TIMEOUT = 4;
   localparam int DEF_CNT_W   = 16;

endpackage : posit_accum_ctrl_pkg
`default_nettype wire

// File: rtl/posit_accum_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | posit_accum_ctrl : sums a packet of posits through an external adder,     |
// | one dependent addition in flight at a time.   Revision: 1.0              |
// +--------------------------------------------------------------------------+
module posit_accum_ctrl
   import posit_accum_ctrl_pkg::*;
#(
   parameter int N       = DEF_N,
   parameter int STAGES  = DEF_STAGES,
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic             aclk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_data,
   output logic [CNT_W-1:0] out_count,
   output logic             err,
   output logic             add_start,
   output logic [N-1:0]     add_in1,
   output logic [N-1:0]     add_in2,
   input  logic [N-1:0]     add_result,
   input  logic             add_done,
   input  logic             add_inf
);

   localparam logic [N-1:0] NAR  = {1'b1, {(N-1){1'b0}}};
   localparam logic [N-1:0] ZERO = '0;

   localparam int WAIT_W = $clog2(STAGES + TIMEOUT + 1);
   localparam int DRN_W  = $clog2(STAGES + 2);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(STAGES + TIMEOUT);
   localparam logic [DRN_W-1:0]  DRAIN_INIT = DRN_W'(STAGES + 1);

   state_e             state_q, state_d;
   logic [N-1:0]       acc_q,   acc_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic               nar_q,   nar_d;
   logic               last_q,  last_d;
   logic [N-1:0]       in1_q,   in1_d;
   logic [N-1:0]       in2_q,   in2_d;
   logic               start_q, start_d;
   logic [WAIT_W-1:0]  wait_q,  wait_d;
   logic [DRN_W-1:0]   drain_q, drain_d;
   logic               err_q,   err_d;

   logic draining;
   logic accept;
   logic done_seen;

   // After reset the external adder may still deliver a pulse for an
   // operation this block has forgotten; the drain window swallows it.
   assign draining  = (drain_q != '0);
   assign in_ready  = ((state_q == S_IDLE) || (state_q == S_ACC)) && !draining;
   assign accept    = in_valid && in_ready;
   assign done_seen = add_done && !draining;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      nar_d   = nar_q;
      last_d  = last_q;
      in1_d   = in1_q;
      in2_d   = in2_q;
      start_d = 1'b0;
      wait_d  = wait_q;
      drain_d = drain_q;
      err_d   = err_q;

      if (draining) begin
         drain_d = drain_q - 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               acc_d   = in_data;
               cnt_d   = CNT_W'(1);
               nar_d   = (in_data == NAR);
               state_d = in_last ? S_OUT : S_ACC;
            end
         end
         S_ACC: begin
            if (accept) begin
               in1_d   = acc_q;
               in2_d   = in_data;
               start_d = 1'b1;
               last_d  = in_last;
               wait_d  = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (done_seen) begin
               acc_d   = add_result;
               cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
               nar_d   = nar_q || add_inf || (add_result == NAR);
               state_d = last_q ? S_OUT : S_ACC;
            end else if (wait_q == WAIT_LIMIT) begin
               err_d   = 1'b1;
               nar_d   = 1'b1;
               state_d = S_OUT;
            end else begin
               wait_d  = wait_q + 1'b1;
            end
         end
         S_OUT: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (done_seen && (state_q != S_WAIT)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge aclk) begin
      if (reset) begin
         state_q <= S_IDLE;
         acc_q   <= ZERO;
         cnt_q   <= '0;
         nar_q   <= 1'b0;
         last_q  <= 1'b0;
         in1_q   <= ZERO;
         in2_q   <= ZERO;
         start_q <= 1'b0;
         wait_q  <= '0;
         drain_q <= DRAIN_INIT;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         nar_q   <= nar_d;
         last_q  <= last_d;
         in1_q   <= in1_d;
         in2_q   <= in2_d;
         start_q <= start_d;
         wait_q  <= wait_d;
         drain_q <= drain_d;
         err_q   <= err_d;
      end
   end

   assign out_valid = (state_q == S_OUT);
   assign out_data  = nar_q ? NAR : acc_q;
   assign out_count = cnt_q;
   assign err       = err_q;
   assign add_start = start_q;
   assign add_in1   = in1_q;
   assign add_in2   = in2_q;

endmodule : posit_accum_ctrl
`default_nettype wire

// File: tb/tb_posit_accum_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_posit_accum_ctrl : directed and random packets against a posit8 es=0   |
// | value-domain adder model.   Revision: 1.0                                |
// +--------------------------------------------------------------------------+
module tb_posit_accum_ctrl;

   localparam int N       = 8;
   localparam int STAGES  = 1;
   localparam int TIMEOUT = 4;
   localparam int CNT_W   = 16;
   localparam logic [7:0] NAR = 8'h80;

   logic             aclk      = 1'b0;
   logic             reset     = 1'b1;
   logic             in_valid  = 1'b0;
   logic [N-1:0]     in_data   = '0;
   logic             in_last   = 1'b0;
   logic             out_ready = 1'b0;
   logic             in_ready;
   logic             out_valid;
   logic [N-1:0]     out_data;
   logic [CNT_W-1:0] out_count;
   logic             err;
   logic             add_start;
   logic [N-1:0]     add_in1;
   logic [N-1:0]     add_in2;
   logic [N-1:0]     add_result;
   logic             add_done;
   logic             add_inf;

   logic       mdl_done = 1'b0;
   logic       mdl_inf  = 1'b0;
   logic [7:0] mdl_res  = '0;
   logic       inj_done = 1'b0;
   logic [7:0] inj_res  = '0;
   bit         withhold = 1'b0;

   int total = 0;
   int bad   = 0;
   int n_starts = 0;
   int n_viol   = 0;
   int val [256];

   assign add_done   = mdl_done | inj_done;
   assign add_result = inj_done ? inj_res : mdl_res;
   assign add_inf    = mdl_inf & ~inj_done;

   always #5 aclk = ~aclk;

   posit_accum_ctrl #(
      .N(N), .STAGES(STAGES), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
   ) dut (
      .aclk(aclk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
      .err(err),
      .add_start(add_start), .add_in1(add_in1), .add_in2(add_in2),
      .add_result(add_result), .add_done(add_done), .add_inf(add_inf)
   );

   // Posit8 es=0 value scaled by 64 (minpos = 2^-6 becomes 1); NaR decodes to 0.
   function automatic int decode(input logic [7:0] p);
      logic [7:0] m;
      bit r, stop;
      int run, k, nf, f, mag;
      if (p == 8'h00 || p == NAR) return 0;
      m = p[7] ? (~p + 8'd1) : p;
      r = m[6];
      run = 0;
      stop = 1'b0;
      for (int i = 6; i >= 0; i--) begin
         if (!stop) begin
            if (m[i] == r) run++;
            else stop = 1'b1;
         end
      end
      k   = r ? run - 1 : -run;
      nf  = (run >= 6) ? 0 : 6 - run;
      f   = int'(m) & ((1 << nf) - 1);
      mag = (((1 << nf) + f) << (k + 6)) >> nf;
      return p[7] ? -mag : mag;
   endfunction

   // Nearest posit by value, ties to the even pattern, never rounding to 0 or NaR.
   function automatic logic [7:0] encode(input int v);
      int mag, best, bestd, d;
      if (v == 0) return 8'h00;
      mag = (v < 0) ? -v : v;
      best = 1;
      bestd = 32'h7fffffff;
      for (int p = 1; p < 128; p++) begin
         d = mag - val[p];
         if (d < 0) d = -d;
         if (d < bestd || (d == bestd && (p % 2) == 0)) begin
            best  = p;
            bestd = d;
         end
      end
      return (v < 0) ? 8'(256 - best) : 8'(best);
   endfunction

   function automatic logic [7:0] padd(input logic [7:0] a, input logic [7:0] b);
      if (a == NAR || b == NAR) return NAR;
      return encode(val[a] + val[b]);
   endfunction

   // Attached adder: done one cycle after the start cycle, unless withheld.
   always begin
      logic [7:0] a, b;
      @(negedge aclk);
      if (add_start && !withhold) begin
         a = add_in1;
         b = add_in2;
         @(posedge aclk);
         #1;
         mdl_res  = padd(a, b);
         mdl_inf  = (a == NAR) || (b == NAR);
         mdl_done = 1'b1;
         @(posedge aclk);
         #1;
         mdl_done = 1'b0;
         mdl_inf  = 1'b0;
      end
   end

   always @(negedge aclk) begin
      if (add_start) n_starts++;
      if (add_start && in_ready) n_viol++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s did not hold", tag);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge aclk);
         #1;
      end
   endtask

   task automatic push(input logic [7:0] d, input logic l);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!in_ready && n < 64) begin
         cycles(1);
         n++;
      end
      check("push_ready_bound", 32'(n < 64), 1);
      cycles(1);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic pop(input string tag, input logic [7:0] ed, input int ec, input logic ee,
                      input int hold);
      int n;
      n = 0;
      while (!out_valid && n < 64) begin
         cycles(1);
         n++;
      end
      check({tag, "_valid"}, 32'(out_valid), 1);
      check({tag, "_data"},  32'(out_data), 32'(ed));
      check({tag, "_count"}, 32'(out_count), 32'(ec));
      check({tag, "_err"},   32'(err), 32'(ee));
      for (int i = 0; i < hold; i++) begin
         cycles(1);
         check({tag, "_hold_valid"}, 32'(out_valid), 1);
         check({tag, "_hold_data"},  32'(out_data), 32'(ed));
         check({tag, "_hold_count"}, 32'(out_count), 32'(ec));
      end
      out_ready = 1'b1;
      check({tag, "_nobypass"}, 32'(in_ready), 0);
      cycles(1);
      out_ready = 1'b0;
      check({tag, "_released"}, 32'(out_valid), 0);
   endtask

   initial begin
      int s0, len, nar_exp;
      logic [7:0] ops [$];
      logic [7:0] acc;

      for (int p = 0; p < 256; p++) val[p] = decode(8'(p));

      reset = 1'b1;
      cycles(3);
      check("rst_in_ready",  32'(in_ready), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_add_start", 32'(add_start), 0);
      check("rst_err",       32'(err), 0);
      check("rst_out_data",  32'(out_data), 0);
      check("rst_out_count", 32'(out_count), 0);
      reset = 1'b0;
      cycles(1);
      check("drain_in_ready", 32'(in_ready), 0);
      cycles(1);
      check("post_drain_in_ready", 32'(in_ready), 1);

      // 1.0 + 1.0
      s0 = n_starts;
      push(8'h40, 1'b0);
      push(8'h40, 1'b1);
      pop("two_ones", 8'h60, 2, 1'b0, 0);
      check("two_ones_starts", 32'(n_starts - s0), 1);

      // 0.5 + 0.5 + 1.0
      s0 = n_starts;
      push(8'h20, 1'b0);
      push(8'h20, 1'b0);
      push(8'h40, 1'b1);
      pop("three_terms", 8'h60, 3, 1'b0, 0);
      check("three_terms_starts", 32'(n_starts - s0), 2);

      // single-term packet bypasses the adder
      s0 = n_starts;
      push(8'h20, 1'b1);
      pop("single", 8'h20, 1, 1'b0, 0);
      check("single_starts", 32'(n_starts - s0), 0);

      // NaR operand, consumer stalls for 5 cycles
      push(8'h40, 1'b0);
      push(NAR, 1'b1);
      pop("nar_stall", NAR, 2, 1'b0, 5);

      // adder never answers: timeout, then a normal packet still sums
      withhold = 1'b1;
      push(8'h40, 1'b0);
      push(8'h40, 1'b1);
      pop("timeout", NAR, 1, 1'b1, 0);
      withhold = 1'b0;
      push(8'h20, 1'b0);
      push(8'h20, 1'b1);
      pop("after_timeout", 8'h40, 2, 1'b1, 0);

      // reset one cycle after add_start, stale done right after release
      withhold = 1'b1;
      push(8'h40, 1'b0);
      push(8'h40, 1'b1);
      check("pre_reset_start", 32'(add_start), 1);
      cycles(1);
      reset = 1'b1;
      cycles(1);
      reset = 1'b0;
      inj_res  = 8'h55;
      inj_done = 1'b1;
      cycles(1);
      inj_done = 1'b0;
      withhold = 1'b0;
      check("stale_err",       32'(err), 0);
      check("stale_out_data",  32'(out_data), 0);
      check("stale_out_count", 32'(out_count), 0);
      check("stale_out_valid", 32'(out_valid), 0);
      push(8'h60, 1'b0);
      push(8'h20, 1'b1);
      pop("after_reset", 8'h64, 2, 1'b0, 0);

      // random packets against the value-domain model
      for (int pk = 0; pk < 25; pk++) begin
         len = $urandom_range(1, 5);
         ops.delete();
         for (int i = 0; i < len; i++) begin
            ops.push_back(($urandom_range(0, 7) == 0) ? NAR : 8'($urandom_range(0, 255)));
         end
         acc = ops[0];
         nar_exp = (acc == NAR) ? 1 : 0;
         for (int i = 1; i < len; i++) begin
            acc = padd(acc, ops[i]);
            if (acc == NAR) nar_exp = 1;
         end
         if (nar_exp != 0) acc = NAR;
         for (int i = 0; i < len; i++) push(ops[i], (i == len - 1) ? 1'b1 : 1'b0);
         pop("rand", acc, len, 1'b0, int'($urandom_range(0, 2)));
      end

      check("no_ready_during_wait", 32'(n_viol), 0);

      // done pulse with nothing in flight
      cycles(2);
      inj_res  = 8'h33;
      inj_done = 1'b1;
      cycles(1);
      inj_done = 1'b0;
      check("unexpected_done_err",   32'(err), 1);
      check("unexpected_done_valid", 32'(out_valid), 0);
      check("unexpected_done_ready", 32'(in_ready), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_posit_accum_ctrl
`default_nettype wire
